// File: rtl/jtag_reg_access_ctrl_pkg.sv
// Shared register-file widths, constants and access-controller state encodings.
package jtag_reg_access_ctrl_pkg;

    localparam int RegAddrBusW = 5;
    localparam int RegBusW     = 32;

    localparam logic [RegAddrBusW-1:0] ZeroReg     = '0;
    localparam logic [RegBusW-1:0]     ZeroWord    = '0;
    localparam logic                   WriteEnable = 1'b1;

    typedef enum logic [1:0] {
        JRA_IDLE = 2'b00,
        JRA_SLOT = 2'b01,
        JRA_RESP = 2'b10
    } jra_state_e;

endpackage

// File: rtl/jtag_reg_access_ctrl_if.sv
// Debug request/response channel, core writeback monitor and regfile debug port.
interface jtag_reg_access_ctrl_if
    import jtag_reg_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = RegAddrBusW,
    parameter int DATA_W = RegBusW
);
    logic              dbg_req_valid_i;
    logic              dbg_req_ready_o;
    logic              dbg_req_we_i;
    logic [ADDR_W-1:0] dbg_req_addr_i;
    logic [DATA_W-1:0] dbg_req_wdata_i;
    logic              dbg_rsp_valid_o;
    logic              dbg_rsp_ready_i;
    logic [DATA_W-1:0] dbg_rsp_rdata_o;
    logic              dbg_rsp_err_o;
    logic              core_we_i;
    logic [ADDR_W-1:0] core_waddr_i;
    logic              rf_jtag_we_o;
    logic [ADDR_W-1:0] rf_jtag_addr_o;
    logic [DATA_W-1:0] rf_jtag_wdata_o;
    logic [DATA_W-1:0] rf_jtag_rdata_i;
    logic              core_hold_o;

    modport slave (
        input  dbg_req_valid_i, dbg_req_we_i, dbg_req_addr_i, dbg_req_wdata_i,
        input  dbg_rsp_ready_i, core_we_i, core_waddr_i, rf_jtag_rdata_i,
        output dbg_req_ready_o, dbg_rsp_valid_o, dbg_rsp_rdata_o, dbg_rsp_err_o,
        output rf_jtag_we_o, rf_jtag_addr_o, rf_jtag_wdata_o, core_hold_o
    );

    modport master (
        output dbg_req_valid_i, dbg_req_we_i, dbg_req_addr_i, dbg_req_wdata_i,
        output dbg_rsp_ready_i, core_we_i, core_waddr_i, rf_jtag_rdata_i,
        input  dbg_req_ready_o, dbg_rsp_valid_o, dbg_rsp_rdata_o, dbg_rsp_err_o,
        input  rf_jtag_we_o, rf_jtag_addr_o, rf_jtag_wdata_o, core_hold_o
    );

endinterface

// File: rtl/jtag_reg_access_ctrl_starve_timer.sv
// Saturating count of SLOT cycles that found no usable regfile slot.
module jra_starve_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);
    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != CNT_LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hit = (cnt_q == CNT_LIMIT);

endmodule

// File: rtl/jtag_reg_access_ctrl.sv
// Serialises JTAG register reads/writes onto the regfile debug port around core writebacks.
// Optional starvation hold: define JTAG_REG_STARVE_HOLD_EN.
//
// state    | meaning
// JRA_IDLE | ready for a debug request
// JRA_SLOT | request latched, waiting for a cycle free of conflicting core writeback
// JRA_RESP | response presented, held until the debug module takes it
module jtag_reg_access_ctrl
    import jtag_reg_access_ctrl_pkg::*;
#(
    parameter int ADDR_W       = RegAddrBusW,
    parameter int DATA_W       = RegBusW,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    jtag_reg_access_ctrl_if.slave  bus
);
    if (STARVE_LIMIT < 1) begin : g_limit_chk
        $error("STARVE_LIMIT must be at least 1");
    end

    jra_state_e        state_q, state_d;
    logic              we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              accept, slot, cap_err;
    logic [DATA_W-1:0] cap_rdata;

    assign accept = (state_q == JRA_IDLE) && bus.dbg_req_valid_i;

    always_comb begin
        state_d              = state_q;
        slot                 = 1'b0;
        cap_rdata            = DATA_W'(ZeroWord);
        cap_err              = 1'b0;
        bus.dbg_req_ready_o  = 1'b0;
        bus.dbg_rsp_valid_o  = 1'b0;
        bus.rf_jtag_we_o     = 1'b0;
        bus.rf_jtag_addr_o   = '0;
        bus.rf_jtag_wdata_o  = '0;
        unique case (state_q)
            JRA_IDLE: begin
                bus.dbg_req_ready_o = 1'b1;
                if (bus.dbg_req_valid_i) state_d = JRA_SLOT;
            end
            JRA_SLOT: begin
                bus.rf_jtag_addr_o  = addr_q;
                bus.rf_jtag_wdata_o = wdata_q;
                if (addr_q == ADDR_W'(ZeroReg)) begin
                    // x0 never touches the port; writes to it are reported as errors
                    slot    = 1'b1;
                    cap_err = we_q;
                end else if (we_q) begin
                    // the regfile debug-write gate also needs a nonzero core address
                    slot             = !bus.core_we_i && (bus.core_waddr_i != '0);
                    bus.rf_jtag_we_o = slot && !rst ? WriteEnable : 1'b0;
                end else begin
                    slot      = !(bus.core_we_i && (bus.core_waddr_i == addr_q));
                    cap_rdata = bus.rf_jtag_rdata_i;
                end
                if (slot) state_d = JRA_RESP;
            end
            JRA_RESP: begin
                bus.dbg_rsp_valid_o = 1'b1;
                if (bus.dbg_rsp_ready_i) state_d = JRA_IDLE;
            end
            default: state_d = JRA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= JRA_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.dbg_req_we_i;
                addr_q  <= bus.dbg_req_addr_i;
                wdata_q <= bus.dbg_req_wdata_i;
            end
            if ((state_q == JRA_SLOT) && slot) begin
                rdata_q <= cap_rdata;
                err_q   <= cap_err;
            end
        end
    end

    assign bus.dbg_rsp_rdata_o = rdata_q;
    assign bus.dbg_rsp_err_o   = err_q;

`ifdef JTAG_REG_STARVE_HOLD_EN
    logic starve_inc, starve_hit;

    assign starve_inc = (state_q == JRA_SLOT) && !slot;

    jra_starve_timer #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_timer (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .inc (starve_inc),
        .hit (starve_hit)
    );

    assign bus.core_hold_o = (state_q == JRA_SLOT) && starve_hit && !rst;
`else
    assign bus.core_hold_o = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_reg_access_ctrl.sv
// Randomised scoreboard bench for jtag_reg_access_ctrl with a cycle-level slot/response model.
module tb_jtag_reg_access_ctrl;
    import jtag_reg_access_ctrl_pkg::*;

    localparam int LIMIT = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk, rst;
    jtag_reg_access_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    jtag_reg_access_ctrl #(
        .ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] rf_mem [32];
    logic [31:0] shadow [32];
    exp_t        sb [$];

    int          phase = 0;
    int          starve = 0;
    logic        pend_we;
    logic [4:0]  pend_addr;
    logic [31:0] pend_wdata;

    int core_mode = 0;
    int rsp_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rf_jtag_rdata_i = rf_mem[bus.rf_jtag_addr_o];

    always @(posedge clk) begin
        if (bus.rf_jtag_we_o) rf_mem[bus.rf_jtag_addr_o] <= bus.rf_jtag_wdata_o;
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    // core writeback and response-ready drivers
    always @(posedge clk) begin
        #1;
        case (core_mode)
            0: begin bus.core_we_i = 1'b0; bus.core_waddr_i = 5'($urandom_range(1, 31)); end
            1: begin bus.core_we_i = 1'b1; bus.core_waddr_i = 5'($urandom_range(0, 31)); end
            2: begin bus.core_we_i = 1'b1; bus.core_waddr_i = 5'd9; end
            default: begin bus.core_we_i = 1'($urandom % 2); bus.core_waddr_i = 5'($urandom % 32); end
        endcase
        case (rsp_mode)
            0: bus.dbg_rsp_ready_i = 1'b1;
            1: bus.dbg_rsp_ready_i = 1'($urandom % 2);
            default: bus.dbg_rsp_ready_i = 1'b0;
        endcase
    end

    // monitor: one request in flight; it completes in the first cycle the core leaves a usable slot
    always @(negedge clk) begin
        logic legal, exp_we, exp_hold;
        if (rst) begin
            chk1("rst_no_write", bus.rf_jtag_we_o, 1'b0);
            chk1("rst_no_hold", bus.core_hold_o, 1'b0);
            phase = 0;
            starve = 0;
            sb.delete();
        end else begin
            exp_hold = 1'b0;
`ifdef JTAG_REG_STARVE_HOLD_EN
            exp_hold = (phase == 1) && (starve >= LIMIT);
`endif
            chk1("core_hold", bus.core_hold_o, exp_hold);
            chk1("req_ready", bus.dbg_req_ready_o, phase == 0);
            case (phase)
                0: begin
                    chk1("idle_rsp_valid", bus.dbg_rsp_valid_o, 1'b0);
                    chk1("idle_rf_we", bus.rf_jtag_we_o, 1'b0);
                    if (bus.dbg_req_valid_i && bus.dbg_req_ready_o) begin
                        pend_we    = bus.dbg_req_we_i;
                        pend_addr  = bus.dbg_req_addr_i;
                        pend_wdata = bus.dbg_req_wdata_i;
                        starve     = 0;
                        phase      = 1;
                    end
                end
                1: begin
                    chk1("slot_rsp_valid", bus.dbg_rsp_valid_o, 1'b0);
                    chk32("slot_rf_addr", 32'(bus.rf_jtag_addr_o), 32'(pend_addr));
                    if (pend_addr == 5'd0)
                        legal = 1'b1;
                    else if (pend_we)
                        legal = !bus.core_we_i && (bus.core_waddr_i != 5'd0);
                    else
                        legal = !(bus.core_we_i && (bus.core_waddr_i == pend_addr));
                    exp_we = legal && pend_we && (pend_addr != 5'd0);
                    chk1("slot_rf_we", bus.rf_jtag_we_o, exp_we);
                    if (exp_we) chk32("slot_rf_wdata", bus.rf_jtag_wdata_o, pend_wdata);
                    if (legal) phase = 2;
                    else starve++;
                end
                default: begin
                    chk1("resp_rsp_valid", bus.dbg_rsp_valid_o, 1'b1);
                    chk1("resp_rf_we", bus.rf_jtag_we_o, 1'b0);
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected_rsp actual=rsp expected=none at %0t", $time);
                    end else begin
                        chk32("rsp_rdata", bus.dbg_rsp_rdata_o, sb[0].rdata);
                        chk1("rsp_err", bus.dbg_rsp_err_o, sb[0].err);
                        if (bus.dbg_rsp_ready_i) void'(sb.pop_front());
                    end
                    if (bus.dbg_rsp_ready_i) phase = 0;
                end
            endcase
        end
    end

    // stimulus is driven 1 time unit after the rising edge
    task automatic issue(input logic we, input logic [4:0] a, input logic [31:0] d, input bit commit);
        int  n = 0;
        bit  acc = 0;
        exp_t e;
        bus.dbg_req_valid_i = 1'b1;
        bus.dbg_req_we_i    = we;
        bus.dbg_req_addr_i  = a;
        bus.dbg_req_wdata_i = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.dbg_req_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        bus.dbg_req_valid_i = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL req_accept_timeout actual=not_ready expected=accept at %0t", $time);
        end else if (commit) begin
            e.rdata = 32'd0;
            e.err   = 1'b0;
            if (we) begin
                if (a == 5'd0) e.err = 1'b1;
                else shadow[a] = d;
            end else if (a != 5'd0) begin
                e.rdata = shadow[a];
            end
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((phase != 0 || sb.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (phase != 0 || sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=pending%0d expected=none at %0t", sb.size(), $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            shadow[i] = (i == 0) ? 32'd0 : $urandom;
            rf_mem[i] = shadow[i];
        end
        rst = 1'b1;
        bus.dbg_req_valid_i = 1'b0;
        bus.dbg_req_we_i    = 1'b0;
        bus.dbg_req_addr_i  = '0;
        bus.dbg_req_wdata_i = '0;
        bus.dbg_rsp_ready_i = 1'b1;
        bus.core_we_i       = 1'b0;
        bus.core_waddr_i    = 5'd1;
        cycles(3);
        rst = 1'b0;

        chk1("reset_ready", bus.dbg_req_ready_o, 1'b1);
        chk1("reset_rsp_valid", bus.dbg_rsp_valid_o, 1'b0);
        chk32("reset_rdata", bus.dbg_rsp_rdata_o, 32'd0);
        chk1("reset_err", bus.dbg_rsp_err_o, 1'b0);
        chk32("reset_rf_addr", 32'(bus.rf_jtag_addr_o), 32'd0);
        chk32("reset_rf_wdata", bus.rf_jtag_wdata_o, 32'd0);

        // idle core: write then read back x5
        core_mode = 0;
        rsp_mode  = 0;
        issue(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        wait_drain(50);
        issue(1'b0, 5'd5, 32'd0, 1'b1);
        wait_drain(50);
        chk32("x5_written", rf_mem[5], 32'hDEADBEEF);

        // core busy for several cycles, write x7 goes out in the first free cycle
        core_mode = 1;
        issue(1'b1, 5'd7, 32'h0BAD_F00D, 1'b1);
        cycles(5);
        core_mode = 0;
        wait_drain(50);

        // core writing x9: x10 read is unaffected, x9 read waits
        core_mode = 2;
        issue(1'b0, 5'd10, 32'd0, 1'b1);
        wait_drain(50);
        issue(1'b0, 5'd9, 32'd0, 1'b1);
        cycles(6);
        core_mode = 0;
        wait_drain(50);

        // x0 accesses
        issue(1'b1, 5'd0, 32'h1234, 1'b1);
        wait_drain(50);
        issue(1'b0, 5'd0, 32'd0, 1'b1);
        wait_drain(50);

        // response back-pressure
        rsp_mode = 2;
        issue(1'b0, 5'd7, 32'd0, 1'b1);
        cycles(6);
        rsp_mode = 0;
        wait_drain(50);
        cycles(2);

        // prolonged starvation, then release
        core_mode = 1;
        issue(1'b1, 5'd3, 32'hCAFE_0003, 1'b1);
        cycles(8);
        core_mode = 0;
        wait_drain(50);

        // reset while a write is pending in SLOT: no write, no response
        core_mode = 1;
        issue(1'b1, 5'd3, 32'h5555_AAAA, 1'b0);
        cycles(2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        core_mode = 0;
        cycles(6);
        chk32("reset_drop_x3", rf_mem[3], shadow[3]);

        // randomised traffic
        core_mode = 3;
        rsp_mode  = 1;
        for (int k = 0; k < 80; k++) begin
            issue(1'($urandom % 2), 5'($urandom % 8), $urandom, 1'b1);
        end
        wait_drain(400);
        core_mode = 0;
        rsp_mode  = 0;
        for (int i = 1; i < 8; i++) begin
            issue(1'b0, 5'(i), 32'd0, 1'b1);
        end
        wait_drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
